// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared lane type and word-size helpers for the deserializer
// DESER_PARITY_EN adds one even-parity bit after every lane word.
package deser_pkg;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  localparam int DESER_WIDTH_DEF = 8;

  // Bits received per lane word, including the optional parity bit.
  function automatic int deser_nbits(input int width);
`ifdef DESER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/deser_if.sv
// rtl/deser_if.sv - bit-side input bundle and word-side output stream of the deserializer
interface deser_bit_if;
  logic bit_valid;
  logic bit_ready;
  logic bit_sel;
  logic bit_l0;
  logic bit_l1;

  modport master (output bit_valid, bit_sel, bit_l0, bit_l1, input bit_ready);
  modport slave  (input bit_valid, bit_sel, bit_l0, bit_l1, output bit_ready);
endinterface

interface deser_word_if import deser_pkg::*; #(
  parameter int WIDTH = DESER_WIDTH_DEF
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_lane;
  logic             out_perr;

  modport master (output out_valid, out_data, out_lane, out_perr, input out_ready);
  modport slave  (input out_valid, out_data, out_lane, out_perr, output out_ready);
endinterface

// File: rtl/deser_lane.sv
// rtl/deser_lane.sv - one lane: LSB-first shift register, bit counter, single-word hold
// DESER_PARITY_EN: the word carries a trailing even-parity bit checked into perr_o.
module deser_lane import deser_pkg::*; #(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en_i,
  input  logic             bit_d_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             last_o,
  output logic [WIDTH-1:0] data_o,
  output logic             perr_o
);
  localparam int NBITS = deser_nbits(WIDTH);
  localparam int CW    = $clog2(NBITS);

  logic [NBITS-1:0] sh_q, sh_d;
  logic [NBITS-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             done;

  assign last_o = (cnt_q == CW'(NBITS - 1));
  assign done   = bit_en_i && last_o;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    full_d = full_q;
    if (bit_en_i) begin
      sh_d[cnt_q] = bit_d_i;
      cnt_d       = done ? '0 : cnt_q + CW'(1);
    end
    // The top never lets a full lane finish a word, so done and pop never collide.
    if (done) begin
      hold_d = sh_d;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign full_o = full_q;
  assign data_o = hold_q[WIDTH-1:0];

`ifdef DESER_PARITY_EN
  assign perr_o = ^hold_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/deser_2ch.sv
// rtl/deser_2ch.sv - two-lane deserializer with round-robin word output stream
// DESER_PARITY_EN selects the parity-checked word format in each lane.
module deser_2ch import deser_pkg::*; #(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  deser_bit_if.slave   bit_if,
  deser_word_if.master out_if
);
  logic             full0, full1;
  logic             last0, last1;
  logic             perr0, perr1;
  logic [WIDTH-1:0] data0, data1;
  logic             sel_ready, accept, bit_d;
  logic             out_valid, pop;
  lane_t            grant, grant_q, last_grant_q;
  logic             stall_q;

  // A lane only refuses its final bit while its previous word is still waiting.
  assign sel_ready = rst_n && !(bit_if.bit_sel ? (full1 && last1) : (full0 && last0));
  assign accept    = bit_if.bit_valid && sel_ready;
  assign bit_d     = bit_if.bit_sel ? bit_if.bit_l1 : bit_if.bit_l0;

  assign bit_if.bit_ready = sel_ready;

  deser_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en_i (accept && !bit_if.bit_sel),
    .bit_d_i  (bit_d),
    .pop_i    (pop && (grant == LANE0)),
    .full_o   (full0),
    .last_o   (last0),
    .data_o   (data0),
    .perr_o   (perr0)
  );

  deser_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en_i (accept && bit_if.bit_sel),
    .bit_d_i  (bit_d),
    .pop_i    (pop && (grant == LANE1)),
    .full_o   (full1),
    .last_o   (last1),
    .data_o   (data1),
    .perr_o   (perr1)
  );

  assign out_valid = full0 || full1;
  assign pop       = out_valid && out_if.out_ready;

  // A stalled offer keeps its lane even if the other lane fills meanwhile.
  always_comb begin
    if (stall_q) begin
      grant = grant_q;
    end else if (full0 && full1) begin
      grant = (last_grant_q == LANE0) ? LANE1 : LANE0;
    end else if (full1) begin
      grant = LANE1;
    end else begin
      grant = LANE0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q      <= 1'b0;
      grant_q      <= LANE0;
      last_grant_q <= LANE1;
    end else begin
      stall_q <= out_valid && !out_if.out_ready;
      grant_q <= grant;
      if (pop) begin
        last_grant_q <= grant;
      end
    end
  end

  assign out_if.out_valid = out_valid;
  assign out_if.out_lane  = out_valid && (grant == LANE1);
  assign out_if.out_data  = !out_valid ? '0 : ((grant == LANE1) ? data1 : data0);
  assign out_if.out_perr  = out_valid && ((grant == LANE1) ? perr1 : perr0);

endmodule

// File: tb/tb_deser_2ch.sv
// tb/tb_deser_2ch.sv - randomized self-checking bench for deser_2ch with a queue-based lane model
module tb_deser_2ch;
  import deser_pkg::*;

  localparam int W = DESER_WIDTH_DEF;
`ifdef DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deser_bit_if bif ();
  deser_word_if #(.WIDTH(W)) wif ();

  deser_2ch #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_if (bif),
    .out_if (wif)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: received bits per lane, one waiting word per lane, arbitration memory.
  bit m_bits[2][$];
  int m_hold[2];
  bit m_full[2];
  int m_last;
  int m_gprev;
  bit m_stall;

  task automatic m_reset();
    m_bits[0].delete();
    m_bits[1].delete();
    m_hold[0] = 0;
    m_hold[1] = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_last    = 1;
    m_gprev   = 0;
    m_stall   = 1'b0;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int full_word(input int d);
`ifdef DESER_PARITY_EN
    return d | (($countones(d) & 1) << W);
`else
    return d;
`endif
  endfunction

  function automatic bit m_ready(input bit s);
    return !(m_full[s] && m_bits[s].size() == NB - 1);
  endfunction

  function automatic bit m_valid();
    return m_full[0] || m_full[1];
  endfunction

  function automatic int m_grant();
    if (m_stall) return m_gprev;
    if (m_full[0] && m_full[1]) return 1 - m_last;
    if (m_full[1]) return 1;
    return 0;
  endfunction

  function automatic int m_data();
    if (!m_valid()) return 0;
    return m_hold[m_grant()] & MASK;
  endfunction

  function automatic bit m_perr();
`ifdef DESER_PARITY_EN
    if (!m_valid()) return 1'b0;
    return bit'($countones(m_hold[m_grant()]) & 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input bit v, input bit s, input bit l0, input bit l1, input bit r);
    bit acc;
    bit vld;
    int g;
    int w;
    bif.bit_valid = v;
    bif.bit_sel   = s;
    bif.bit_l0    = l0;
    bif.bit_l1    = l1;
    wif.out_ready = r;
    #1;
    acc = v && m_ready(s);
    vld = m_valid();
    g   = m_grant();
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      if (vld && r) begin
        m_full[g] = 1'b0;
        m_last    = g;
      end
      if (acc) begin
        m_bits[s].push_back(s ? l1 : l0);
        if (m_bits[s].size() == NB) begin
          w = 0;
          for (int k = 0; k < NB; k++) w = w | (int'(m_bits[s][k]) << k);
          m_bits[s].delete();
          m_hold[s] = w;
          m_full[s] = 1'b1;
        end
      end
      m_stall = vld && !r;
      m_gprev = g;
    end
    #1;
  endtask

  task automatic feed(input bit s, input int w, input bit r);
    for (int k = 0; k < NB; k++) begin
      drive(1'b1, s, s ? rb() : bit'((w >> k) & 1), s ? bit'((w >> k) & 1) : rb(), r);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (wif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", wif.out_valid); end
    checks++; if (wif.out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", wif.out_data); end
    checks++; if (wif.out_lane !== 1'b0) begin failures++; $display("FAIL rst_lane got=%b exp=0", wif.out_lane); end
    checks++; if (wif.out_perr !== 1'b0) begin failures++; $display("FAIL rst_perr got=%b exp=0", wif.out_perr); end
    checks++; if (bif.bit_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bif.bit_ready); end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bif.bit_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", bif.bit_ready); end
    checks++; if (wif.out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", wif.out_valid); end
  endtask

  task automatic test_single_word();
    int w;
    w = full_word(8'h0D);
    do_reset();
    for (int k = 0; k < NB; k++) begin
      drive(1'b1, 1'b0, bit'((w >> k) & 1), rb(), 1'b0);
      if (k == NB - 2) begin
        checks++; if (wif.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", wif.out_valid); end
      end
    end
    checks++; if (wif.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", wif.out_valid); end
    checks++; if (wif.out_data !== 8'h0D) begin failures++; $display("FAIL single_data got=%h exp=0d", wif.out_data); end
    checks++; if (wif.out_lane !== 1'b0) begin failures++; $display("FAIL single_lane got=%b exp=0", wif.out_lane); end
    checks++; if (wif.out_perr !== 1'b0) begin failures++; $display("FAIL single_perr got=%b exp=0", wif.out_perr); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wif.out_valid !== 1'b0) begin failures++; $display("FAIL single_popped got=%b exp=0", wif.out_valid); end
  endtask

  task automatic test_interleave();
    int wa;
    int wc;
    int k;
    int got_lane[$];
    int got_data[$];
    wa = full_word(8'hA5);
    wc = full_word(8'h3C);
    do_reset();
    for (int step = 0; step < 2 * NB + 3; step++) begin
      k = step / 2;
      if (step >= 2 * NB) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (step % 2 == 0) drive(1'b1, 1'b1, rb(), bit'((wa >> k) & 1), 1'b1);
      else drive(1'b1, 1'b0, bit'((wc >> k) & 1), rb(), 1'b1);
      if (wif.out_valid === 1'b1) begin
        got_lane.push_back(int'(wif.out_lane));
        got_data.push_back(int'(wif.out_data));
      end
    end
    checks++; if (got_lane.size() != 2) begin failures++; $display("FAIL ilv_count got=%0d exp=2", got_lane.size()); end
    if (got_lane.size() == 2) begin
      checks++; if (got_lane[0] != 1) begin failures++; $display("FAIL ilv_lane0 got=%0d exp=1", got_lane[0]); end
      checks++; if (got_data[0] != 'hA5) begin failures++; $display("FAIL ilv_data0 got=%h exp=a5", got_data[0]); end
      checks++; if (got_lane[1] != 0) begin failures++; $display("FAIL ilv_lane1 got=%0d exp=0", got_lane[1]); end
      checks++; if (got_data[1] != 'h3C) begin failures++; $display("FAIL ilv_data1 got=%h exp=3c", got_data[1]); end
    end
  endtask

  task automatic test_round_robin();
    int wa, wb, wc, wd;
    wa = int'($urandom_range(0, MASK));
    wb = int'($urandom_range(0, MASK));
    wc = int'($urandom_range(0, MASK));
    wd = int'($urandom_range(0, MASK));
    do_reset();
    feed(1'b0, full_word(wa), 1'b0);
    feed(1'b1, full_word(wb), 1'b0);
    checks++; if (wif.out_lane !== 1'b0 || wif.out_data !== W'(wa)) begin failures++; $display("FAIL rr_first lane=%b data=%h exp lane=0 data=%h", wif.out_lane, wif.out_data, wa); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wif.out_lane !== 1'b1 || wif.out_data !== W'(wb)) begin failures++; $display("FAIL rr_second lane=%b data=%h exp lane=1 data=%h", wif.out_lane, wif.out_data, wb); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wif.out_valid !== 1'b0) begin failures++; $display("FAIL rr_empty got=%b exp=0", wif.out_valid); end
    feed(1'b1, full_word(wc), 1'b0);
    feed(1'b0, full_word(wd), 1'b0);
    checks++; if (wif.out_lane !== 1'b1 || wif.out_data !== W'(wc)) begin failures++; $display("FAIL rr_stall_hold lane=%b data=%h exp lane=1 data=%h", wif.out_lane, wif.out_data, wc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wif.out_lane !== 1'b0 || wif.out_data !== W'(wd)) begin failures++; $display("FAIL rr_after_hold lane=%b data=%h exp lane=0 data=%h", wif.out_lane, wif.out_data, wd); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int wa, wb, wc, fb;
    wa = int'($urandom_range(0, MASK));
    wb = int'($urandom_range(0, MASK));
    wc = int'($urandom_range(0, MASK));
    fb = full_word(wb);
    do_reset();
    feed(1'b0, full_word(wa), 1'b0);
    for (int k = 0; k < NB - 1; k++) begin
      bif.bit_sel = 1'b0;
      #1;
      checks++; if (bif.bit_ready !== 1'b1) begin failures++; $display("FAIL bp_keep_ready bit=%0d got=%b exp=1", k, bif.bit_ready); end
      drive(1'b1, 1'b0, bit'((fb >> k) & 1), rb(), 1'b0);
    end
    bif.bit_sel = 1'b0;
    #1;
    checks++; if (bif.bit_ready !== 1'b0) begin failures++; $display("FAIL bp_final_blocked got=%b exp=0", bif.bit_ready); end
    drive(1'b1, 1'b0, rb(), rb(), 1'b0);
    bif.bit_sel = 1'b1;
    #1;
    checks++; if (bif.bit_ready !== 1'b1) begin failures++; $display("FAIL bp_other_ready got=%b exp=1", bif.bit_ready); end
    feed(1'b1, full_word(wc), 1'b0);
    checks++; if (wif.out_lane !== 1'b0 || wif.out_data !== W'(wa)) begin failures++; $display("FAIL bp_head lane=%b data=%h exp lane=0 data=%h", wif.out_lane, wif.out_data, wa); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wif.out_lane !== 1'b1 || wif.out_data !== W'(wc)) begin failures++; $display("FAIL bp_lane1 lane=%b data=%h exp lane=1 data=%h", wif.out_lane, wif.out_data, wc); end
    bif.bit_sel = 1'b0;
    #1;
    checks++; if (bif.bit_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%b exp=1", bif.bit_ready); end
    drive(1'b1, 1'b0, bit'((fb >> (NB - 1)) & 1), rb(), 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wif.out_lane !== 1'b0 || wif.out_data !== W'(wb)) begin failures++; $display("FAIL bp_second lane=%b data=%h exp lane=0 data=%h", wif.out_lane, wif.out_data, wb); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midword();
    int wd;
    wd = int'($urandom_range(0, MASK));
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, rb(), rb(), 1'b0);
    do_reset();
    feed(1'b0, full_word(wd), 1'b0);
    checks++; if (wif.out_valid !== 1'b1 || wif.out_data !== W'(wd)) begin failures++; $display("FAIL midrst_word valid=%b data=%h exp valid=1 data=%h", wif.out_valid, wif.out_data, wd); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    do_reset();
    feed(1'b0, 'h001, 1'b0);
    checks++; if (wif.out_perr !== 1'b1 || wif.out_data !== 8'h01) begin failures++; $display("FAIL par_bad perr=%b data=%h exp perr=1 data=01", wif.out_perr, wif.out_data); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    feed(1'b1, 'h101, 1'b0);
    checks++; if (wif.out_perr !== 1'b0 || wif.out_data !== 8'h01) begin failures++; $display("FAIL par_good perr=%b data=%h exp perr=0 data=01", wif.out_perr, wif.out_data); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    bit v, s, l0, l1, r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      s  = rb();
      l0 = rb();
      l1 = rb();
      r  = ($urandom_range(0, 2) != 0);
      bif.bit_valid = v;
      bif.bit_sel   = s;
      bif.bit_l0    = l0;
      bif.bit_l1    = l1;
      wif.out_ready = r;
      #1;
      checks++; if (bif.bit_ready !== m_ready(s)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bif.bit_ready, m_ready(s)); end
      checks++; if (wif.out_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, wif.out_valid, m_valid()); end
      checks++; if (wif.out_data !== W'(m_data())) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, wif.out_data, m_data()); end
      checks++; if (wif.out_lane !== (m_valid() && m_grant() == 1)) begin failures++; $display("FAIL rnd_lane cyc=%0d got=%b exp=%0d", i, wif.out_lane, m_valid() ? m_grant() : 0); end
      checks++; if (wif.out_perr !== m_perr()) begin failures++; $display("FAIL rnd_perr cyc=%0d got=%b exp=%b", i, wif.out_perr, m_perr()); end
      drive(v, s, l0, l1, r);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_word();
    test_interleave();
    test_round_robin();
    test_backpressure();
    test_reset_midword();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
